// File: rtl/control_seq_if.sv
// Sequencer <-> program memory / datapath bundle. The master side is the sequencer;
// the slave side is the environment that supplies instructions and the zero flag.
interface control_seq_if #(
  parameter int NBITS_0 = 11,
  parameter int NBITS_D = 16,
  parameter int NCNT    = 32
);
  logic               i_Start;
  logic               i_StepMode;
  logic               i_Step;
  logic [NBITS_D-1:0] i_Instruction;
  logic               i_InstrValid;
  logic               i_AccZero;
  logic [NBITS_0-1:0] o_Addr;
  logic               o_InstrReq;
  logic [1:0]         o_SelA;
  logic               o_SelB;
  logic               o_WrAcc;
  logic               o_Op;
  logic               o_WrRam;
  logic               o_RdRam;
  logic [NBITS_0-1:0] o_Operand;
  logic               o_Halt;
  logic               o_Busy;
  logic [NCNT-1:0]    o_InstrCount;

  modport master (
    input  i_Start, i_StepMode, i_Step, i_Instruction, i_InstrValid, i_AccZero,
    output o_Addr, o_InstrReq, o_SelA, o_SelB, o_WrAcc, o_Op, o_WrRam, o_RdRam,
           o_Operand, o_Halt, o_Busy, o_InstrCount
  );
  modport slave (
    output i_Start, i_StepMode, i_Step, i_Instruction, i_InstrValid, i_AccZero,
    input  o_Addr, o_InstrReq, o_SelA, o_SelB, o_WrAcc, o_Op, o_WrRam, o_RdRam,
           o_Operand, o_Halt, o_Busy, o_InstrCount
  );
endinterface

// File: rtl/control_seq.sv
// Multi-cycle FETCH/EXEC sequencer for the accumulator CPU: PC, IR, branches,
// single-step pause and a saturating retired-instruction counter.
module control_seq #(
  parameter int NBITS_0 = 11,
  parameter int NBITS_D = 16,
  parameter int OPCODE  = 5,
  parameter int NCNT    = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  control_seq_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_PAUSE, S_HALT} state_t;

  localparam logic [OPCODE-1:0] OP_HLT  = 'd0;
  localparam logic [OPCODE-1:0] OP_STO  = 'd1;
  localparam logic [OPCODE-1:0] OP_LD   = 'd2;
  localparam logic [OPCODE-1:0] OP_LDI  = 'd3;
  localparam logic [OPCODE-1:0] OP_ADD  = 'd4;
  localparam logic [OPCODE-1:0] OP_ADDI = 'd5;
  localparam logic [OPCODE-1:0] OP_SUB  = 'd6;
  localparam logic [OPCODE-1:0] OP_SUBI = 'd7;
  localparam logic [OPCODE-1:0] OP_JMP  = 'd8;
  localparam logic [OPCODE-1:0] OP_BEQ  = 'd9;
  localparam logic [OPCODE-1:0] OP_BNE  = 'd10;

  state_t             state_q;
  logic [NBITS_0-1:0] pc_q, pc_d;
  logic [NBITS_D-1:0] ir_q;
  logic [NCNT-1:0]    cnt_q, cnt_d;
  logic [OPCODE-1:0]  opc;
  logic [NBITS_0-1:0] operand;
  logic               in_exec;

  assign opc     = ir_q[NBITS_D-1 -: OPCODE];
  assign operand = ir_q[NBITS_0-1:0];
  assign in_exec = (state_q == S_EXEC);

  // Only meaningful in EXEC; pc+1 wraps naturally at NBITS_0.
  always_comb begin
    pc_d = pc_q + NBITS_0'(1);
    case (opc)
      OP_HLT: pc_d = pc_q;
      OP_JMP: pc_d = operand;
      OP_BEQ: if (bus.i_AccZero)  pc_d = operand;
      OP_BNE: if (!bus.i_AccZero) pc_d = operand;
      default: ;
    endcase
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + NCNT'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.i_Start) state_q <= S_FETCH;
        S_FETCH: if (bus.i_InstrValid) begin
          ir_q    <= bus.i_Instruction;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          pc_q  <= pc_d;
          cnt_q <= cnt_d;
          if (opc == OP_HLT)       state_q <= S_HALT;
          else if (bus.i_StepMode) state_q <= S_PAUSE;
          else                     state_q <= S_FETCH;
        end
        S_PAUSE: if (bus.i_Step || !bus.i_StepMode) state_q <= S_FETCH;
        S_HALT:  ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_SelA  = 2'd0;
    bus.o_SelB  = 1'b0;
    bus.o_WrAcc = 1'b0;
    bus.o_Op    = 1'b0;
    bus.o_WrRam = 1'b0;
    bus.o_RdRam = 1'b0;
    if (in_exec) begin
      case (opc)
        OP_STO:  bus.o_WrRam = 1'b1;
        OP_LD:   begin bus.o_WrAcc = 1'b1; bus.o_RdRam = 1'b1; end
        OP_LDI:  begin bus.o_SelA = 2'd1; bus.o_WrAcc = 1'b1; end
        OP_ADD, OP_SUB: begin
          bus.o_SelA  = 2'd2;
          bus.o_WrAcc = 1'b1;
          bus.o_RdRam = 1'b1;
          bus.o_Op    = (opc == OP_SUB);
        end
        OP_ADDI, OP_SUBI: begin
          bus.o_SelA  = 2'd2;
          bus.o_SelB  = 1'b1;
          bus.o_WrAcc = 1'b1;
          bus.o_Op    = (opc == OP_SUBI);
        end
        default: ;
      endcase
    end
  end

  assign bus.o_Addr       = pc_q;
  assign bus.o_InstrReq   = (state_q == S_FETCH);
  assign bus.o_Operand    = operand;
  assign bus.o_Halt       = (state_q == S_HALT);
  assign bus.o_Busy       = (state_q == S_FETCH) || in_exec || (state_q == S_PAUSE);
  assign bus.o_InstrCount = cnt_q;
endmodule
